// File: rtl/load_align_ext_unit_if.sv
// Load request / memory data / write-back response bundle.
// slave: the load unit; master: the requesting pipeline side.
interface load_align_ext_unit_if #(
  parameter int XLEN = 64,
  parameter int OFFW = $clog2(XLEN/8)
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [OFFW-1:0] req_offset;
  logic [XLEN-1:0] mem_rdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_misaligned;

  modport slave (
    input  req_valid, req_size, req_unsigned,
    input  req_offset, mem_rdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_misaligned
  );

  modport master (
    output req_valid, req_size, req_unsigned,
    output req_offset, mem_rdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_misaligned
  );
endinterface

// File: rtl/load_align_ext_unit.sv
// Load align/extend unit: fixed-latency read, byte align, sign/zero extend.
// Define LOAD_MISALIGN_TRAP_EN to flag misaligned loads (data forced to 0).
module load_align_ext_unit #(
  parameter int XLEN    = 64,
  parameter int MEM_LAT = 2,
  localparam int OFFW   = $clog2(XLEN/8)
) (
  input logic                  clk,
  input logic                  reset,
  load_align_ext_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int CNTW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            vld_q, vld_d;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sbit;
  logic [XLEN-1:0] result;
  logic            accept;

`ifdef LOAD_MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
  logic            mis_now;
`endif

  assign bus.req_ready = !reset &&
    (state_q == IDLE ||
     (state_q == RESP && bus.rsp_ready));

  assign accept    = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_data  = data_q;

  // Field mask doubles as the extension boundary.
  always_comb begin
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    mask    = '1;
    sbit    = 1'b0;
    unique case (size_q)
      2'd0: begin
        mask = XLEN'(8'hFF);
        sbit = shifted[7];
      end
      2'd1: begin
        mask = XLEN'(16'hFFFF);
        sbit = shifted[15];
      end
      2'd2: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sbit = shifted[31];
      end
      2'd3: begin
        mask = '1;
        sbit = 1'b0;
      end
    endcase
    result = (shifted & mask) |
             ({XLEN{~uns_q & sbit}} & ~mask);
`ifdef LOAD_MISALIGN_TRAP_EN
    mis_now = 1'b0;
    unique case (size_q)
      2'd0: mis_now = 1'b0;
      2'd1: mis_now = off_q[0];
      2'd2: mis_now = |off_q[1:0];
      2'd3: mis_now = |off_q;
    endcase
    if (mis_now) result = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    data_d  = data_q;
    vld_d   = vld_q;
`ifdef LOAD_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    if (accept) begin
      size_d = bus.req_size;
      uns_d  = bus.req_unsigned;
      off_d  = bus.req_offset;
      cnt_d  = CNT_INIT;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = result;
          vld_d   = 1'b1;
          state_d = RESP;
`ifdef LOAD_MISALIGN_TRAP_EN
          mis_d   = mis_now;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          vld_d   = 1'b0;
          state_d = accept ? WAIT : IDLE;
`ifdef LOAD_MISALIGN_TRAP_EN
          mis_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
`ifdef LOAD_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  assign bus.rsp_misaligned = mis_q;
`else
  assign bus.rsp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_align_ext_unit.sv
// Scoreboard bench for load_align_ext_unit (XLEN=64, MEM_LAT=2).
// Memory data is garbage except on each scheduled sample edge.
module tb_load_align_ext_unit;

  localparam int MEM_LAT = 2;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    int          rise;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t        sb[$];
  int          mq_cyc[$];
  logic [63:0] mq_dat[$];

  load_align_ext_unit_if #(.XLEN(64)) bus ();

  load_align_ext_unit #(
    .XLEN(64),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Memory: real data only on the sample edge.
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mq_cyc.size() > 0 && mq_cyc[0] == cyc + 1) begin
        bus.mem_rdata = mq_dat.pop_front();
        void'(mq_cyc.pop_front());
      end else begin
        bus.mem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: checks rise timing and data at each handshake.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got valid at cyc %0d expected none",
                   cyc);
        end else begin
          chk("rise_cyc", 64'(cyc), 64'(sb[0].rise));
        end
      end
      if (!reset && bus.rsp_valid && bus.rsp_ready
          && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_mis", 64'(bus.rsp_misaligned), 64'(e.mis));
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic issue(input logic [1:0]  sz,
                       input logic        u,
                       input logic [2:0]  off,
                       input logic [63:0] md,
                       input logic [63:0] ed,
                       input logic        em,
                       input bit          track);
    int n;
    int t;
    exp_t e;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_offset   = off;
    bus.req_valid    = 1'b1;
    t = cyc + 1;
    if (track) begin
      mq_cyc.push_back(t + MEM_LAT);
      mq_dat.push_back(md);
      e.data = ed;
      e.mis  = em;
      e.rise = t + MEM_LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
    end
  endtask

  initial begin
    int n;
    logic [63:0] mis_d;
    logic        mis_f;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_offset   = '0;
    bus.rsp_ready    = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_mis", 64'(bus.rsp_misaligned), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

    issue(2'd0, 1'b0, 3'd3, 64'h0000_0000_8000_0000,
          64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
    issue(2'd2, 1'b1, 3'd4, 64'h8765_4321_0000_0000,
          64'h0000_0000_8765_4321, 1'b0, 1'b1);
    issue(2'd2, 1'b0, 3'd4, 64'h8765_4321_0000_0000,
          64'hFFFF_FFFF_8765_4321, 1'b0, 1'b1);
    issue(2'd3, 1'b0, 3'd0, 64'hDEAD_BEEF_0123_4567,
          64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
    issue(2'd3, 1'b1, 3'd0, 64'hDEAD_BEEF_0123_4567,
          64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
    issue(2'd0, 1'b0, 3'd0, 64'h1111_2222_3333_447F,
          64'h0000_0000_0000_007F, 1'b0, 1'b1);
    drain();

    // Backpressure: stall in RESP, then release with a new request.
    bus.rsp_ready = 1'b0;
    issue(2'd1, 1'b1, 3'd2, 64'h0000_0000_BEEF_0000,
          64'h0000_0000_0000_BEEF, 1'b0, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data_stable", bus.rsp_data, 64'h0000_0000_0000_BEEF);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    issue(2'd0, 1'b1, 3'd7, 64'h1200_0000_0000_0000,
          64'h0000_0000_0000_0012, 1'b0, 1'b1);
    chk("bp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    drain();
    repeat (2) @(negedge clk);

    // Reset while waiting on memory aborts the load.
    issue(2'd0, 1'b0, 3'd1, 64'h0, 64'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_rsp_data", bus.rsp_data, 64'd0);
    chk("abort_rsp_mis", 64'(bus.rsp_misaligned), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    issue(2'd1, 1'b0, 3'd6, 64'h8001_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b1);
    drain();

    // Misaligned half at the top byte.
`ifdef LOAD_MISALIGN_TRAP_EN
    mis_d = 64'h0;
    mis_f = 1'b1;
`else
    mis_d = 64'h0000_0000_0000_00AB;
    mis_f = 1'b0;
`endif
    issue(2'd1, 1'b0, 3'd7, 64'hAB00_0000_0000_0000,
          mis_d, mis_f, 1'b1);
    issue(2'd1, 1'b0, 3'd6, 64'hAB00_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_AB00, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
